// File: rtl/iob_div_pipe_pkg.sv
// Shared defaults and the stage-count helper for the pipelined divider.
package iob_div_pipe_pkg;

    localparam int DIV_DATA_W_DEF = 32;
    localparam int DIV_OPERS_DEF  = 8;

    function automatic int div_nstages(input int data_w, input int opers_per_stage);
        return data_w / opers_per_stage;
    endfunction

endpackage

// File: rtl/iob_div_pipe_stage.sv
// OPERS_PER_STAGE chained restoring shift-subtract steps, purely combinational.
module iob_div_pipe_stage
    import iob_div_pipe_pkg::*;
#(
    parameter int DATA_W          = DIV_DATA_W_DEF,
    parameter int OPERS_PER_STAGE = DIV_OPERS_DEF
) (
    input  logic [DATA_W-1:0] div_i,
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] shreg_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] shreg_o
);

    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] shreg;

    // shreg holds the unconsumed dividend bits at the top and the quotient bits at the bottom
    always_comb begin
        rem   = rem_i;
        shreg = shreg_i;
        trial = '0;
        for (int i = 0; i < OPERS_PER_STAGE; i++) begin
            trial = {rem, shreg[DATA_W-1]};
            shreg = shreg << 1;
            if (trial >= {1'b0, div_i}) begin
                rem      = trial[DATA_W-1:0] - div_i;
                shreg[0] = 1'b1;
            end else begin
                rem = trial[DATA_W-1:0];
            end
        end
    end

    assign rem_o   = rem;
    assign shreg_o = shreg;

endmodule

// File: rtl/iob_div_pipe.sv
// Fully pipelined unsigned divider, one operand pair per clock, latency NSTAGES, no stall.
module iob_div_pipe
    import iob_div_pipe_pkg::*;
#(
    parameter int DATA_W          = DIV_DATA_W_DEF,
    parameter int OPERS_PER_STAGE = DIV_OPERS_DEF
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);

    localparam int NSTAGES = div_nstages(DATA_W, OPERS_PER_STAGE);

    logic [DATA_W-1:0] div_in   [NSTAGES];
    logic [DATA_W-1:0] rem_in   [NSTAGES];
    logic [DATA_W-1:0] shreg_in [NSTAGES];
    logic              vld_in   [NSTAGES];
    logic [DATA_W-1:0] rem_nx   [NSTAGES];
    logic [DATA_W-1:0] shreg_nx [NSTAGES];
    logic [DATA_W-1:0] div_d    [NSTAGES];
    logic [DATA_W-1:0] rem_d    [NSTAGES];
    logic [DATA_W-1:0] shreg_d  [NSTAGES];
    logic [DATA_W-1:0] div_q    [NSTAGES];
    logic [DATA_W-1:0] rem_q    [NSTAGES];
    logic [DATA_W-1:0] shreg_q  [NSTAGES];
    logic              vld_q    [NSTAGES];

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        if (k == 0) begin : g_load
            assign div_in[k]   = divisor_i;
            assign rem_in[k]   = '0;
            assign shreg_in[k] = dividend_i;
            assign vld_in[k]   = 1'b1;
        end else begin : g_chain
            assign div_in[k]   = div_q[k-1];
            assign rem_in[k]   = rem_q[k-1];
            assign shreg_in[k] = shreg_q[k-1];
            assign vld_in[k]   = vld_q[k-1];
        end

        iob_div_pipe_stage #(
            .DATA_W          (DATA_W),
            .OPERS_PER_STAGE (OPERS_PER_STAGE)
        ) u_stage (
            .div_i   (div_in[k]),
            .rem_i   (rem_in[k]),
            .shreg_i (shreg_in[k]),
            .rem_o   (rem_nx[k]),
            .shreg_o (shreg_nx[k])
        );

        // Post-reset bubbles travel as zeros so the outputs read 0 until real data arrives
        assign div_d[k]   = vld_in[k] ? div_in[k]   : '0;
        assign rem_d[k]   = vld_in[k] ? rem_nx[k]   : '0;
        assign shreg_d[k] = vld_in[k] ? shreg_nx[k] : '0;

        always_ff @(posedge clk_i or posedge arst_i) begin
            if (arst_i) begin
                vld_q[k]   <= 1'b0;
                div_q[k]   <= '0;
                rem_q[k]   <= '0;
                shreg_q[k] <= '0;
            end else begin
                vld_q[k]   <= vld_in[k];
                div_q[k]   <= div_d[k];
                rem_q[k]   <= rem_d[k];
                shreg_q[k] <= shreg_d[k];
            end
        end
    end

    assign quotient_o  = shreg_q[NSTAGES-1];
    assign remainder_o = rem_q[NSTAGES-1];

endmodule

// File: tb/tb_iob_div_pipe.sv
// Random and directed checks of iob_div_pipe at 32/8, 16/4 and exhaustive 8/1 against an arithmetic model.
module tb_iob_div_pipe;

    localparam int NA = 4;  // 32 / 8
    localparam int NB = 4;  // 16 / 4
    localparam int NC = 8;  // 8 / 1

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_a, arst_b, arst_c;
    logic [31:0] dvd_a, dvs_a, q_a, r_a;
    logic [15:0] dvd_b, dvs_b, q_b, r_b;
    logic [7:0]  dvd_c, dvs_c, q_c, r_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] dir_dvd [6] = '{32'd100, 32'd7,   32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd12345};
    logic [31:0] dir_dvs [6] = '{32'd7,   32'd100, 32'd1,         32'h8000_0000, 32'd5, 32'd0};
    logic [31:0] dir_q   [6] = '{32'd14,  32'd0,   32'hFFFF_FFFF, 32'd1,         32'd0, 32'hFFFF_FFFF};
    logic [31:0] dir_r   [6] = '{32'd2,   32'd7,   32'd0,         32'd0,         32'd0, 32'd12345};

    iob_div_pipe #(.DATA_W(32), .OPERS_PER_STAGE(8)) u_dut_a (
        .clk_i(clk), .arst_i(arst_a), .dividend_i(dvd_a), .divisor_i(dvs_a),
        .quotient_o(q_a), .remainder_o(r_a));
    iob_div_pipe #(.DATA_W(16), .OPERS_PER_STAGE(4)) u_dut_b (
        .clk_i(clk), .arst_i(arst_b), .dividend_i(dvd_b), .divisor_i(dvs_b),
        .quotient_o(q_b), .remainder_o(r_b));
    iob_div_pipe #(.DATA_W(8), .OPERS_PER_STAGE(1)) u_dut_c (
        .clk_i(clk), .arst_i(arst_c), .dividend_i(dvd_c), .divisor_i(dvs_c),
        .quotient_o(q_c), .remainder_o(r_c));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Unsigned divide of w-bit operands; divisor 0 gives all ones and the dividend back
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input int w,
                                    output logic [31:0] q, output logic [31:0] r);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        a = a & m;
        b = b & m;
        if (b == 0) begin
            q = m;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic run_a();
        logic [31:0] eq[$];
        logic [31:0] er[$];
        logic [31:0] a, b, q, r;
        bit post_rst = 1'b0;
        arst_a = 1'b1; dvd_a = '0; dvs_a = '0;
        repeat (2) @(negedge clk);
        check_eq("a_rst_q", q_a, 32'd0);
        check_eq("a_rst_r", r_a, 32'd0);
        arst_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dvd_a = dir_dvd[i]; dvs_a = dir_dvs[i];
            repeat (NA) @(negedge clk);
            check_eq($sformatf("a_dir%0d_q", i), q_a, dir_q[i]);
            check_eq($sformatf("a_dir%0d_r", i), r_a, dir_r[i]);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 50) begin
                arst_a = 1'b1;
                #1;
                check_eq("a_midrst_q", q_a, 32'd0);
                check_eq("a_midrst_r", r_a, 32'd0);
                @(negedge clk);
                arst_a = 1'b0;
                eq.delete(); er.delete();
                post_rst = 1'b1;
            end
            if (eq.size() == NA) begin
                check_eq($sformatf("a_str%0d_q", i), q_a, eq.pop_front());
                check_eq($sformatf("a_str%0d_r", i), r_a, er.pop_front());
            end else if (post_rst) begin
                check_eq($sformatf("a_flush%0d_q", i), q_a, 32'd0);
                check_eq($sformatf("a_flush%0d_r", i), r_a, 32'd0);
            end
            a = $urandom & 32'h7FFF_FFFF;
            b = ($urandom & 32'h7FFF_FFFF) >> $urandom_range(0, 30);
            dvd_a = a; dvs_a = b;
            ref_div(a, b, 32, q, r);
            eq.push_back(q); er.push_back(r);
        end
        while (eq.size() != 0) begin
            @(negedge clk);
            check_eq("a_drain_q", q_a, eq.pop_front());
            check_eq("a_drain_r", r_a, er.pop_front());
        end
    endtask

    task automatic run_b();
        logic [31:0] eq[$];
        logic [31:0] er[$];
        logic [31:0] a, b, q, r;
        arst_b = 1'b1; dvd_b = '0; dvs_b = '0;
        repeat (2) @(negedge clk);
        check_eq("b_rst_q", {16'd0, q_b}, 32'd0);
        arst_b = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (eq.size() == NB) begin
                check_eq($sformatf("b_str%0d_q", i), {16'd0, q_b}, eq.pop_front());
                check_eq($sformatf("b_str%0d_r", i), {16'd0, r_b}, er.pop_front());
            end
            a = 32'($urandom_range(0, 16'hFFFF));
            b = 32'($urandom_range(0, 16'hFFFF)) >> $urandom_range(0, 16);
            dvd_b = a[15:0]; dvs_b = b[15:0];
            ref_div(a, b, 16, q, r);
            eq.push_back(q); er.push_back(r);
        end
        while (eq.size() != 0) begin
            @(negedge clk);
            check_eq("b_drain_q", {16'd0, q_b}, eq.pop_front());
            check_eq("b_drain_r", {16'd0, r_b}, er.pop_front());
        end
    endtask

    task automatic run_c();
        logic [31:0] eq[$];
        logic [31:0] er[$];
        logic [31:0] q, r;
        arst_c = 1'b1; dvd_c = '0; dvs_c = '0;
        repeat (2) @(negedge clk);
        check_eq("c_rst_r", {24'd0, r_c}, 32'd0);
        arst_c = 1'b0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                @(negedge clk);
                if (eq.size() == NC) begin
                    check_eq($sformatf("c_q_%0d_%0d", a, b), {24'd0, q_c}, eq.pop_front());
                    check_eq($sformatf("c_r_%0d_%0d", a, b), {24'd0, r_c}, er.pop_front());
                end
                dvd_c = 8'(a); dvs_c = 8'(b);
                ref_div(32'(a), 32'(b), 8, q, r);
                eq.push_back(q); er.push_back(r);
            end
        end
        while (eq.size() != 0) begin
            @(negedge clk);
            check_eq("c_drain_q", {24'd0, q_c}, eq.pop_front());
            check_eq("c_drain_r", {24'd0, r_c}, er.pop_front());
        end
    endtask

    initial begin
        fork
            run_a();
            run_b();
            run_c();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
